// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream bundle shared by the write (slave) and read (master) sides of axis_pkt_fifo.
interface axis_pkt_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with a registered output stage; define AXIS_PKT_FIFO_PACKET_MODE_EN
// to hold words back until a complete packet is stored (store-and-forward).
module axis_pkt_fifo #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_areset,
  axis_pkt_fifo_if.slave         s_axis,
  axis_pkt_fifo_if.master        m_axis,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   oversize
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned WW = DATA_WIDTH + 2;

  // Word layout is {tuser, tlast, tdata}.
  logic [WW-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_n, rptr_q, rptr_n;
  logic [LW-1:0] mcnt_q, mcnt_n, level_q, level_n;
  logic          ov_q, ov_n;
  logic [WW-1:0] out_q, out_n;
  logic          tvalid_q, tvalid_n;
  logic          ready_q, ready_n;
  logic          af_q, af_n, ae_q, ae_n;

  logic          push, pop, out_free, mem_rd, mem_wr, load_in;
  logic [WW-1:0] in_word, mem_word;

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
  logic [LW-1:0] pcnt_q, pcnt_n;
  logic          ovs_q, ovs_n;
`endif

  // Handshakes, output-stage refill, and next-state of counters and flags.
  always_comb begin
    in_word  = {s_axis.tuser, s_axis.tlast, s_axis.tdata};
    mem_word = mem[rptr_q];
    push     = s_axis.tvalid && ready_q;
    pop      = tvalid_q && m_axis.tready;
    out_free = !ov_q || pop;
    mem_rd   = out_free && (mcnt_q != '0);
    load_in  = out_free && (mcnt_q == '0) && push;
    mem_wr   = push && !load_in;

    ov_n  = ov_q;
    out_n = out_q;
    if (out_free) begin
      if (mem_rd) begin
        ov_n  = 1'b1;
        out_n = mem_word;
      end else if (load_in) begin
        ov_n  = 1'b1;
        out_n = in_word;
      end else begin
        ov_n  = 1'b0;
      end
    end

    wptr_n  = mem_wr ? wptr_q + AW'(1) : wptr_q;
    rptr_n  = mem_rd ? rptr_q + AW'(1) : rptr_q;
    mcnt_n  = mcnt_q + LW'(mem_wr) - LW'(mem_rd);
    level_n = level_q + LW'(push) - LW'(pop);
    ready_n = level_n < LW'(DEPTH);
    af_n    = 32'(level_n) >= ALMOST_FULL_TH;
    ae_n    = 32'(level_n) <= ALMOST_EMPTY_TH;

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
    // Oversize lets a packet larger than the FIFO cut through until its tlast leaves.
    pcnt_n = pcnt_q + LW'(push && s_axis.tlast) - LW'(pop && out_q[DATA_WIDTH]);
    ovs_n  = ovs_q;
    if (ovs_q && pop && out_q[DATA_WIDTH]) begin
      ovs_n = 1'b0;
    end else if ((level_n == LW'(DEPTH)) && (pcnt_n == '0)) begin
      ovs_n = 1'b1;
    end
    tvalid_n = ov_n && ((pcnt_n != '0) || ovs_n);
`else
    tvalid_n = ov_n;
`endif
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      mcnt_q   <= '0;
      level_q  <= '0;
      ov_q     <= 1'b0;
      out_q    <= '0;
      tvalid_q <= 1'b0;
      ready_q  <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wptr_q   <= wptr_n;
      rptr_q   <= rptr_n;
      mcnt_q   <= mcnt_n;
      level_q  <= level_n;
      ov_q     <= ov_n;
      out_q    <= out_n;
      tvalid_q <= tvalid_n;
      ready_q  <= ready_n;
      af_q     <= af_n;
      ae_q     <= ae_n;
    end
  end

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      pcnt_q <= '0;
      ovs_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_n;
      ovs_q  <= ovs_n;
    end
  end
  assign oversize = ovs_q;
`else
  assign oversize = 1'b0;
`endif

  // Storage array is data-only; stale contents are never observable.
  always_ff @(posedge s_axis_aclk) begin
    if (mem_wr) begin
      mem[wptr_q] <= in_word;
    end
  end

  assign s_axis.tready = ready_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = out_q[DATA_WIDTH-1:0];
  assign m_axis.tlast  = out_q[DATA_WIDTH];
  assign m_axis.tuser  = out_q[DATA_WIDTH+1];
  assign level         = level_q;
  assign almost_full   = af_q;
  assign almost_empty  = ae_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed self-checking bench for axis_pkt_fifo (DATA_WIDTH=8, DEPTH=16); packet-mode
// steps run when AXIS_PKT_FIFO_PACKET_MODE_EN is defined.
module tb_axis_pkt_fifo;

  logic       clk;
  logic       rst;
  logic [4:0] level;
  logic       almost_full, almost_empty, oversize;

  axis_pkt_fifo_if #(.DATA_WIDTH(8)) s_if ();
  axis_pkt_fifo_if #(.DATA_WIDTH(8)) m_if ();

  axis_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .level         (level),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .oversize      (oversize)
  );

  int checks = 0;
  int errors = 0;
  int mlvl, pushes, idx_in, idx_out;
  logic [8:0] q [$];
  logic [8:0] exp_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tready", s_if.tready, 0);
    chk("rst_level", level, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_oversize", oversize, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("rel_tready", s_if.tready, 1);

    // Three single-word packets back-to-back with the sink always ready.
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1; s_if.tlast = 1'b1;
    s_if.tdata = 8'h11; tick();
    chk("a_valid1", m_if.tvalid, 1); chk("a_data1", m_if.tdata, 8'h11); chk("a_lvl1", level, 1);
    s_if.tdata = 8'h22; tick();
    chk("a_valid2", m_if.tvalid, 1); chk("a_data2", m_if.tdata, 8'h22); chk("a_lvl2", level, 1);
    s_if.tdata = 8'h33; tick();
    chk("a_valid3", m_if.tvalid, 1); chk("a_data3", m_if.tdata, 8'h33);
    s_if.tvalid = 1'b0; tick();
    chk("a_valid_end", m_if.tvalid, 0); chk("a_lvl_end", level, 0); chk("a_ae", almost_empty, 1);

    // Fill with the sink stalled: only 16 of 20 words fit.
    m_if.tready = 1'b0;
    mlvl = 0;
    for (int i = 0; i < 20; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 8'(8'h40 + i); s_if.tlast = 1'b1;
      chk("b_tready", s_if.tready, (mlvl < 16) ? 1 : 0);
      if (mlvl < 16) mlvl++;
      tick();
      chk("b_level", level, mlvl);
      chk("b_af", almost_full, (mlvl >= 14) ? 1 : 0);
      chk("b_ae", almost_empty, (mlvl <= 2) ? 1 : 0);
    end
    s_if.tvalid = 1'b0;
    chk("b_full_tready", s_if.tready, 0);
    chk("b_head", m_if.tdata, 8'h40);
    m_if.tready = 1'b1;
    tick();
    chk("b_pop_tready", s_if.tready, 1);
    chk("b_pop_level", level, 15);
    for (int j = 1; j < 16; j++) begin
      chk("b_drain_valid", m_if.tvalid, 1);
      chk("b_drain_data", m_if.tdata, 8'(8'h40 + j));
      tick();
    end
    chk("b_empty_valid", m_if.tvalid, 0);
    chk("b_empty_level", level, 0);

    // Continuous push against a randomly stalling sink, scoreboard-checked.
    pushes = 0;
    q.delete();
    for (int c = 0; c < 160; c++) begin
      s_if.tvalid = 1'b1; s_if.tlast = 1'b1;
      s_if.tdata = 8'($urandom); s_if.tuser = 1'($urandom);
      m_if.tready = ($urandom_range(0, 3) != 0);
      if (m_if.tvalid && m_if.tready) begin
        if (q.size() == 0) chk("c_spurious", 1, 0);
        else begin
          exp_word = q.pop_front();
          chk("c_data", {m_if.tuser, m_if.tdata}, exp_word);
        end
      end
      if (s_if.tvalid && s_if.tready) begin
        q.push_back({s_if.tuser, s_if.tdata});
        pushes++;
      end
      tick();
      chk("c_level", level, q.size());
    end
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      if (m_if.tvalid) begin
        exp_word = q.pop_front();
        chk("c_drain", {m_if.tuser, m_if.tdata}, exp_word);
      end
      tick();
    end
    chk("c_drained", q.size(), 0);
    chk("c_final_level", level, 0);
    chk("c_wraps", (pushes >= 80) ? 1 : 0, 1);

    // Reset while seven words are stored.
    m_if.tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 8'(8'hA0 + i); s_if.tlast = 1'b1;
      tick();
    end
    s_if.tvalid = 1'b0;
    chk("d_level7", level, 7);
    chk("d_valid7", m_if.tvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("d_rst_valid", m_if.tvalid, 0);
    chk("d_rst_tready", s_if.tready, 0);
    chk("d_rst_level", level, 0);
    chk("d_rst_tdata", m_if.tdata, 0);
    chk("d_rst_ae", almost_empty, 1);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("d_rel_tready", s_if.tready, 1);
    chk("d_rel_valid", m_if.tvalid, 0);
    chk("d_rel_level", level, 0);
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1; s_if.tdata = 8'h5A; s_if.tlast = 1'b1;
    tick();
    chk("d_fresh_data", m_if.tdata, 8'h5A);
    chk("d_fresh_valid", m_if.tvalid, 1);
    s_if.tvalid = 1'b0;
    tick();
    chk("d_after_valid", m_if.tvalid, 0);
    chk("d_after_level", level, 0);

`ifdef AXIS_PKT_FIFO_PACKET_MODE_EN
    // Five-word packet is held until its tlast is stored.
    m_if.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 8'(i + 1); s_if.tlast = (i == 4);
      tick();
      chk("e_valid_hold", m_if.tvalid, (i == 4) ? 1 : 0);
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("e_valid", m_if.tvalid, 1);
      chk("e_data", m_if.tdata, k);
      chk("e_tlast", m_if.tlast, (k == 5) ? 1 : 0);
      tick();
    end
    chk("e_done_valid", m_if.tvalid, 0);
    chk("e_done_level", level, 0);

    // Twenty-word packet overflows the FIFO and is cut through.
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 8'(8'h60 + i); s_if.tlast = 1'b0;
      tick();
      chk("f_oversize_fill", oversize, (i == 15) ? 1 : 0);
    end
    chk("f_level16", level, 16);
    chk("f_valid16", m_if.tvalid, 1);
    chk("f_tready16", s_if.tready, 0);
    m_if.tready = 1'b1;
    idx_in = 16;
    idx_out = 0;
    for (int c = 0; c < 80 && idx_out < 20; c++) begin
      s_if.tvalid = (idx_in < 20);
      s_if.tdata = 8'(8'h60 + idx_in);
      s_if.tlast = (idx_in == 19);
      if (m_if.tvalid && m_if.tready) begin
        chk("f_data", m_if.tdata, 8'(8'h60 + idx_out));
        chk("f_tlast", m_if.tlast, (idx_out == 19) ? 1 : 0);
        if (idx_out == 19) chk("f_oversize_held", oversize, 1);
        idx_out++;
      end
      if (s_if.tvalid && s_if.tready) idx_in++;
      tick();
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    chk("f_count", idx_out, 20);
    chk("f_oversize_clear", oversize, 0);
    chk("f_final_level", level, 0);
`else
    chk("np_oversize", oversize, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: tdata width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16: word capacity, power of two, 4..1024.
REQ-003 SHALL have parameter ALMOST_FULL_TH, default DEPTH-2: almost_full asserts when level >= this value.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 2: almost_empty asserts when level <= this value.
REQ-005 SHALL have port s_axis_aclk  in  1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port s_axis_areset  in  1: asynchronous, active-high reset.
REQ-007 SHALL have ports s_axis_tdata/tvalid/tlast/tuser  in  DATA_WIDTH/1/1/1: write-side AXI-Stream slave inputs.
REQ-008 SHALL have port s_axis_tready  out  1: write-side ready.
REQ-009 SHALL have ports m_axis_tdata/tvalid/tlast/tuser  out  DATA_WIDTH/1/1/1: read-side AXI-Stream master outputs.
REQ-010 SHALL have port m_axis_tready  in  1: read-side ready.
REQ-011 SHALL have port level  out  clog2(DEPTH)+1: stored word count.
REQ-012 SHALL have ports almost_full, almost_empty  out  1 each: threshold flags.
REQ-013 SHALL have port oversize  out  1: a packet longer than DEPTH is being forced through in packet mode.

Function
REQ-014 SHALL accept a word on every edge where s_axis_tvalid && s_axis_tready, storing {tuser, tlast, tdata}.
REQ-015 SHALL drive s_axis_tready = (level < DEPTH); this is independent of s_axis_tvalid.
REQ-016 SHALL register all m_axis_* outputs (output register stage), with no combinational path from s_axis_* to m_axis_*.
REQ-017 SHALL present a word accepted on edge k to an empty FIFO with m_axis_tvalid high from after edge k onward (1-cycle latency).
REQ-018 SHALL hold m_axis_tdata/tlast/tuser stable while m_axis_tvalid && !m_axis_tready.
REQ-019 SHALL pop on m_axis_tvalid && m_axis_tready, refilling the output register on the same edge if further data is stored, so a full-rate stream has no bubbles.
REQ-020 SHALL count in level every word stored, output register included; capacity is exactly DEPTH.
REQ-021 SHALL handle simultaneous push and pop with level unchanged; push while full is impossible (tready low); a pop with level==DEPTH raises tready on the next cycle.
REQ-022 SHALL wrap read and write pointers modulo DEPTH with no gap.
REQ-023 SHALL preserve word order exactly, including tlast/tuser.
REQ-024 SHALL update almost_full and almost_empty as registered flags that are consistent with level in the same cycle.

Reset
REQ-025 SHALL, on s_axis_areset high, immediately clear the pointers and level and drive m_axis_tvalid=0, m_axis_tdata/tlast/tuser=0, s_axis_tready=0, almost_full=0, almost_empty=1, oversize=0.
REQ-026 SHALL raise s_axis_tready on the first edge after reset deasserts; a reset mid-packet discards all stored data.

Configuration
REQ-027 SHALL compile packet mode with macro AXIS_PKT_FIFO_PACKET_MODE_EN.
REQ-028 SHALL, with the macro defined, keep a complete-packet counter (incremented on accepted tlast, decremented on popped tlast). m_axis_tvalid is asserted only when the output register is loaded and (counter > 0 or oversize).
REQ-029 SHALL, with the macro defined, set oversize when level==DEPTH and the counter is 0. The FIFO then cuts through until the popped word has tlast=1, after which oversize clears on the next edge.
REQ-030 SHALL, with the macro undefined, operate as plain FWFT with oversize tied to 0 and no packet counter logic.

Verification
REQ-031 Reset then push 0x11,0x22,0x33 back-to-back with m_axis_tready=1 -> m_axis_tvalid rises 1 cycle after the first push; output is 0x11,0x22,0x33 on consecutive cycles; level ends at 0.
REQ-032 DEPTH=16, m_axis_tready=0, push 20 words -> 16 accepted; s_axis_tready=0 with level=16; almost_full=1 at level 14; then pop 1 -> s_axis_tready=1 on the next cycle.
REQ-033 Continuous push and pop for 100 cycles with random m_axis_tready -> output sequence equals input sequence; level stays <= DEPTH; the pointers wrap at least 5 times.
REQ-034 PACKET_MODE_EN, push a 5-word packet with tlast on word 5 -> m_axis_tvalid stays 0 until after the tlast push, then the 5 words stream out with tlast on the 5th.
REQ-035 PACKET_MODE_EN, DEPTH=16, push a 20-word packet -> oversize=1 at level 16; all 20 words arrive in order; oversize returns to 0 after tlast is popped.
REQ-036 Assert s_axis_areset mid-stream with level=7 -> outputs take their reset values asynchronously; after release, level=0 and no stale word appears.
